// File: rtl/serial_out_channel.sv
// ---------------------------------------------------------------------------
// serial_out_channel
//
// Shifts a latched DATA_BIT-wide pattern out on a single wire, LSB first.
// Each bit is held for a programmable number of clocks, chosen per bit
// between a "slow" and a "fast" period by a companion frequency pattern.
// A frame can be sent once (one-shot), looped until aborted (continue), or
// sent a programmed number of times back-to-back (repeat).
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous reset, active high (name kept from the
//                   existing codebase)
//   data_pattern_i  bit pattern to send
//   freq_pattern_i  per-bit speed select, 1 = fast period, 0 = slow period
//   slow_period_i   clocks per slow bit (0 behaves as 1)
//   fast_period_i   clocks per fast bit (0 behaves as 1)
//   mode_i          00 one-shot, 01 continue, 10 repeat, 11 one-shot
//   repeat_i        number of frames in repeat mode (0 behaves as 1)
//   start_i         single-cycle start pulse, honoured only in IDLE
//   stop_i          single-cycle abort pulse
//   serial_o        serial data out
//   busy_o          high while the block is not IDLE
//   bit_tick_o      pulse on the last clock of every transmitted bit
//   done_tick_o     pulse when a one-shot or repeat run completes normally
//
// Timing: the output stage is one clock behind the sequencing state. The
// edge that accepts start_i moves the FSM to SHIFT, and serial_o shows bit 0
// from the following edge on. bit_tick_o and the final DONE cycle follow
// the same one-clock offset so that all outputs stay mutually aligned.
// ---------------------------------------------------------------------------
module serial_out_channel #(
    parameter int DATA_BIT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_BIT-1:0] data_pattern_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [7:0]          slow_period_i,
    input  logic [7:0]          fast_period_i,
    input  logic [1:0]          mode_i,
    input  logic [7:0]          repeat_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                serial_o,
    output logic                busy_o,
    output logic                bit_tick_o,
    output logic                done_tick_o
);

    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;

    // Copies of the configuration taken when a run is accepted
    logic [DATA_BIT-1:0] data_q;
    logic [DATA_BIT-1:0] freq_q;
    logic [7:0]          slow_q;
    logic [7:0]          fast_q;
    logic [1:0]          mode_q;
    logic [7:0]          repeat_q;

    // Sequencing counters
    logic [7:0]          cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          frame_q;

    // Registered outputs
    logic                serial_q;
    logic                busy_q;
    logic                bit_tick_q;
    logic                done_tick_q;

    logic [7:0]          bitPeriod;
    logic [7:0]          repeatCount;
    logic                lastCycle;
    logic                lastBit;
    logic                lastFrame;

    // Period of the bit currently being sent and the end-of-bit / frame
    // conditions derived from it. Zero periods and a zero repeat count are
    // folded to one so a run always makes progress.
    always_comb begin
        bitPeriod = freq_q[idx_q] ? fast_q : slow_q;
        if (bitPeriod == 8'd0) begin
            bitPeriod = 8'd1;
        end
        repeatCount = (repeat_q == 8'd0) ? 8'd1 : repeat_q;
        lastCycle   = (cnt_q == bitPeriod - 8'd1);
        lastBit     = (idx_q == LAST_IDX);
        lastFrame   = (frame_q == repeatCount - 8'd1);
    end

    // Main FSM. Outputs are computed from the current state so they lag the
    // sequencing by one clock; the exception is the abort path, which
    // clears the outputs on the same edge that returns the FSM to IDLE.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            freq_q      <= '0;
            slow_q      <= 8'd0;
            fast_q      <= 8'd0;
            mode_q      <= 2'd0;
            repeat_q    <= 8'd0;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            frame_q     <= 8'd0;
            serial_q    <= 1'b0;
            busy_q      <= 1'b0;
            bit_tick_q  <= 1'b0;
            done_tick_q <= 1'b0;
        end else begin
            bit_tick_q  <= 1'b0;
            done_tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b0;
                    busy_q   <= 1'b0;
                    // A simultaneous stop cancels the start request
                    if (start_i && !stop_i) begin
                        data_q   <= data_pattern_i;
                        freq_q   <= freq_pattern_i;
                        slow_q   <= slow_period_i;
                        fast_q   <= fast_period_i;
                        mode_q   <= mode_i;
                        repeat_q <= repeat_i;
                        cnt_q    <= 8'd0;
                        idx_q    <= '0;
                        frame_q  <= 8'd0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (stop_i) begin
                        serial_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        serial_q   <= data_q[idx_q];
                        bit_tick_q <= lastCycle;
                        busy_q     <= 1'b1;
                        if (!lastCycle) begin
                            cnt_q <= cnt_q + 8'd1;
                        end else begin
                            cnt_q <= 8'd0;
                            if (!lastBit) begin
                                idx_q <= idx_q + IDX_W'(1);
                            end else begin
                                // End of frame: wrap without a gap cycle
                                // unless the run is finished
                                idx_q   <= '0;
                                frame_q <= frame_q + 8'd1;
                                case (mode_q)
                                    2'b01: begin
                                        state_q <= SHIFT;
                                    end
                                    2'b10: begin
                                        if (lastFrame) begin
                                            state_q <= DONE;
                                        end
                                    end
                                    default: begin
                                        state_q <= DONE;
                                    end
                                endcase
                            end
                        end
                    end
                end

                DONE: begin
                    serial_q    <= 1'b0;
                    done_tick_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end

                default: begin
                    serial_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign serial_o    = serial_q;
    assign busy_o      = busy_q;
    assign bit_tick_o  = bit_tick_q;
    assign done_tick_o = done_tick_q;

endmodule

// File: tb/tb_serial_out_channel.sv
// ---------------------------------------------------------------------------
// tb_serial_out_channel
//
// Directed bench for serial_out_channel. Two instances share clock and
// reset: dutA uses the default 32-bit frame, dutB an 8-bit frame. Inputs
// are driven and outputs sampled on the falling clock edge. After each
// start pulse the outputs are logged once per clock (sample 0 is the
// falling edge right after the accepting rising edge, so data bit 0 first
// appears in sample 1) and the log is compared against hand-derived
// expectations.
// ---------------------------------------------------------------------------
module tb_serial_out_channel;

    logic        clk;
    logic        rst_n;

    logic [31:0] dataA;
    logic [31:0] freqA;
    logic [7:0]  slowA;
    logic [7:0]  fastA;
    logic [1:0]  modeA;
    logic [7:0]  repA;
    logic        startA;
    logic        stopA;
    logic        serA;
    logic        busyA;
    logic        tickA;
    logic        doneA;

    logic [7:0]  dataB;
    logic [7:0]  freqB;
    logic [7:0]  slowB;
    logic [7:0]  fastB;
    logic [1:0]  modeB;
    logic [7:0]  repB;
    logic        startB;
    logic        stopB;
    logic        serB;
    logic        busyB;
    logic        tickB;
    logic        doneB;

    int          checkCount;
    int          failCount;

    logic        logSer  [0:599];
    logic        logBusy [0:599];
    logic        logTick [0:599];
    logic        logDone [0:599];
    int          logLen;

    serial_out_channel #(.DATA_BIT(32)) dutA (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_pattern_i (dataA),
        .freq_pattern_i (freqA),
        .slow_period_i  (slowA),
        .fast_period_i  (fastA),
        .mode_i         (modeA),
        .repeat_i       (repA),
        .start_i        (startA),
        .stop_i         (stopA),
        .serial_o       (serA),
        .busy_o         (busyA),
        .bit_tick_o     (tickA),
        .done_tick_o    (doneA)
    );

    serial_out_channel #(.DATA_BIT(8)) dutB (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_pattern_i (dataB),
        .freq_pattern_i (freqB),
        .slow_period_i  (slowB),
        .fast_period_i  (fastB),
        .mode_i         (modeB),
        .repeat_i       (repB),
        .start_i        (startB),
        .stop_i         (stopB),
        .serial_o       (serB),
        .busy_o         (busyB),
        .bit_tick_o     (tickB),
        .done_tick_o    (doneB)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Load a configuration into one instance and pulse start for one clock
    task automatic applyStimulus(input bit useB, input logic [31:0] data,
                                 input logic [31:0] freq, input logic [7:0] slow,
                                 input logic [7:0] fast, input logic [1:0] mode,
                                 input logic [7:0] rep);
        @(negedge clk);
        if (useB) begin
            dataB = data[7:0];
            freqB = freq[7:0];
            slowB = slow;
            fastB = fast;
            modeB = mode;
            repB  = rep;
            startB = 1'b1;
        end else begin
            dataA = data;
            freqA = freq;
            slowA = slow;
            fastA = fast;
            modeA = mode;
            repA  = rep;
            startA = 1'b1;
        end
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Log nSamples falling-edge samples; optionally pulse start (with a
    // scrambled configuration) or stop at a given sample index
    task automatic captureRun(input bit useB, input int nSamples,
                              input int startAt, input int stopAt);
        for (int s = 0; s < nSamples; s++) begin
            if (s > 0) @(negedge clk);
            if (useB) begin
                logSer[s]  = serB;
                logBusy[s] = busyB;
                logTick[s] = tickB;
                logDone[s] = doneB;
            end else begin
                logSer[s]  = serA;
                logBusy[s] = busyA;
                logTick[s] = tickA;
                logDone[s] = doneA;
            end
            startA = 1'b0;
            stopA  = 1'b0;
            startB = 1'b0;
            stopB  = 1'b0;
            if (s == startAt) begin
                if (useB) begin
                    dataB = 8'h00;
                    freqB = 8'hFF;
                    modeB = 2'b00;
                    startB = 1'b1;
                end else begin
                    dataA = 32'h0;
                    freqA = 32'hFFFF_FFFF;
                    modeA = 2'b00;
                    startA = 1'b1;
                end
            end
            if (s == stopAt) begin
                if (useB) stopB = 1'b1;
                else      stopA = 1'b1;
            end
        end
        logLen = nSamples;
    endtask

    function automatic int countTicks(input int lo, input int hi);
        int n = 0;
        for (int s = lo; s <= hi && s < logLen; s++) if (logTick[s] === 1'b1) n++;
        return n;
    endfunction

    function automatic int countDones(input int lo, input int hi);
        int n = 0;
        for (int s = lo; s <= hi && s < logLen; s++) if (logDone[s] === 1'b1) n++;
        return n;
    endfunction

    // Sample index of the n-th (1-based) bit tick, -1 if absent
    function automatic int nthTick(input int n);
        int seen = 0;
        for (int s = 0; s < logLen; s++) begin
            if (logTick[s] === 1'b1) begin
                seen++;
                if (seen == n) return s;
            end
        end
        return -1;
    endfunction

    function automatic int firstDone();
        for (int s = 0; s < logLen; s++) if (logDone[s] === 1'b1) return s;
        return -1;
    endfunction

    // Count samples in 1..maxS whose serial value differs from the expected
    // stream; bit durations are supplied by the caller
    function automatic int streamErrors(input logic [31:0] data, input logic [31:0] freq,
                                        input int nBits, input int slowDur,
                                        input int fastDur, input int frames,
                                        input int maxS);
        int errs = 0;
        int s = 1;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < nBits; i++) begin
                int dur = (freq[i] == 1'b1) ? fastDur : slowDur;
                for (int k = 0; k < dur; k++) begin
                    if (s <= maxS && s < logLen && logSer[s] !== data[i]) errs++;
                    s++;
                end
            end
        end
        return errs;
    endfunction

    initial begin
        checkCount = 0;
        failCount  = 0;
        logLen     = 0;
        rst_n  = 1'b1;
        dataA = 32'h0; freqA = 32'h0; slowA = 8'h0; fastA = 8'h0;
        modeA = 2'b00; repA = 8'h0; startA = 1'b0; stopA = 1'b0;
        dataB = 8'h0; freqB = 8'h0; slowB = 8'h0; fastB = 8'h0;
        modeB = 2'b00; repB = 8'h0; startB = 1'b0; stopB = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_outA", 32'({serA, busyA, tickA, doneA}), 32'h0);
        checkOutput("rst_outB", 32'({serB, busyB, tickB, doneB}), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);

        // One-shot, mixed periods: bit0 slow (20), bit1 slow, bit2 fast (5);
        // 10 fast + 22 slow bits = 490 clocks
        $display("[TB] one-shot mixed periods");
        applyStimulus(1'b0, 32'hBBCC_DDEE, 32'h1122_3344, 8'h14, 8'h05, 2'b00, 8'h00);
        captureRun(1'b0, 495, -1, -1);
        checkOutput("os_busy_s0",   32'(logBusy[0]), 32'h1);
        checkOutput("os_bit0_s1",   32'(logSer[1]),  32'h0);
        checkOutput("os_bit0_s20",  32'(logSer[20]), 32'h0);
        checkOutput("os_bit1_s21",  32'(logSer[21]), 32'h1);
        checkOutput("os_tick1",     32'(nthTick(1)),  32'd20);
        checkOutput("os_tick2",     32'(nthTick(2)),  32'd40);
        checkOutput("os_tick3",     32'(nthTick(3)),  32'd45);
        checkOutput("os_tick32",    32'(nthTick(32)), 32'd490);
        checkOutput("os_tickcount", 32'(countTicks(0, 494)), 32'd32);
        checkOutput("os_stream",    32'(streamErrors(32'hBBCC_DDEE, 32'h1122_3344, 32, 20, 5, 1, 490)), 32'd0);
        checkOutput("os_donepos",   32'(firstDone()), 32'd491);
        checkOutput("os_donecount", 32'(countDones(0, 494)), 32'd1);
        checkOutput("os_ser_done",  32'(logSer[491]),  32'h0);
        checkOutput("os_busy_last", 32'(logBusy[490]), 32'h1);
        checkOutput("os_busy_done", 32'(logBusy[491]), 32'h0);

        // Repeat x3 on the 8-bit instance: 0xA5 at 2 clocks/bit, 48 clocks
        $display("[TB] repeat three frames");
        applyStimulus(1'b1, 32'hA5, 32'h00, 8'h02, 8'h07, 2'b10, 8'h03);
        captureRun(1'b1, 52, -1, -1);
        checkOutput("rp_stream",    32'(streamErrors(32'hA5, 32'h00, 8, 2, 2, 3, 48)), 32'd0);
        checkOutput("rp_tickcount", 32'(countTicks(0, 51)), 32'd24);
        checkOutput("rp_tick1",     32'(nthTick(1)), 32'd2);
        checkOutput("rp_donepos",   32'(firstDone()), 32'd49);
        checkOutput("rp_donecount", 32'(countDones(0, 51)), 32'd1);
        checkOutput("rp_busy_last", 32'(logBusy[48]), 32'h1);
        checkOutput("rp_busy_done", 32'(logBusy[49]), 32'h0);
        checkOutput("rp_ser_done",  32'(logSer[49]),  32'h0);

        // Repeat count 0 behaves as a single frame
        $display("[TB] repeat count zero");
        applyStimulus(1'b1, 32'h3C, 32'h00, 8'h01, 8'h01, 2'b10, 8'h00);
        captureRun(1'b1, 12, -1, -1);
        checkOutput("rp0_stream",    32'(streamErrors(32'h3C, 32'h00, 8, 1, 1, 1, 8)), 32'd0);
        checkOutput("rp0_donepos",   32'(firstDone()), 32'd9);
        checkOutput("rp0_donecount", 32'(countDones(0, 11)), 32'd1);

        // Continue mode, ignored start at sample 5, stop in frame 2 bit 5
        $display("[TB] continue with stop");
        applyStimulus(1'b1, 32'hA5, 32'h00, 8'h02, 8'h02, 2'b01, 8'h00);
        captureRun(1'b1, 40, 5, 27);
        checkOutput("ct_stream",    32'(streamErrors(32'hA5, 32'h00, 8, 2, 2, 2, 27)), 32'd0);
        checkOutput("ct_ser_pre",   32'(logSer[27]),  32'h1);
        checkOutput("ct_busy_pre",  32'(logBusy[27]), 32'h1);
        checkOutput("ct_ser_stop",  32'(logSer[28]),  32'h0);
        checkOutput("ct_busy_stop", 32'(logBusy[28]), 32'h0);
        checkOutput("ct_tick_stop", 32'(logTick[28]), 32'h0);
        checkOutput("ct_donecount", 32'(countDones(0, 39)), 32'd0);
        checkOutput("ct_busy_late", 32'(logBusy[39]), 32'h0);

        // Zero periods with all-fast select: one clock per bit, mode 11
        $display("[TB] zero periods");
        applyStimulus(1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 8'h00, 8'h00, 2'b11, 8'h00);
        captureRun(1'b0, 36, -1, -1);
        checkOutput("zp_stream",    32'(streamErrors(32'h1234_5678, 32'hFFFF_FFFF, 32, 1, 1, 1, 32)), 32'd0);
        checkOutput("zp_tickcount", 32'(countTicks(0, 35)), 32'd32);
        checkOutput("zp_tick1",     32'(nthTick(1)), 32'd1);
        checkOutput("zp_tick32",    32'(nthTick(32)), 32'd32);
        checkOutput("zp_donepos",   32'(firstDone()), 32'd33);

        // Start together with stop in IDLE is refused
        $display("[TB] start with stop in idle");
        @(negedge clk);
        dataA = 32'hFFFF_FFFF; modeA = 2'b00; slowA = 8'h01;
        startA = 1'b1;
        stopA  = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        stopA  = 1'b0;
        checkOutput("ss_busy",  32'(busyA), 32'h0);
        checkOutput("ss_ser",   32'(serA),  32'h0);
        repeat (3) @(negedge clk);
        checkOutput("ss_busy_late", 32'(busyA), 32'h0);

        // Asynchronous reset at bit 10, then a fresh run
        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 8'h02, 8'h02, 2'b00, 8'h00);
        captureRun(1'b0, 22, -1, -1);
        checkOutput("ar_ser_pre",  32'(logSer[21]),  32'h1);
        checkOutput("ar_busy_pre", 32'(logBusy[21]), 32'h1);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("ar_out_async", 32'({serA, busyA, tickA, doneA}), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("ar_out_after", 32'({serA, busyA, tickA, doneA}), 32'h0);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 8'h01, 8'h01, 2'b00, 8'h00);
        captureRun(1'b0, 36, -1, -1);
        checkOutput("ar_fresh_stream", 32'(streamErrors(32'h0000_0005, 32'h0, 32, 1, 1, 1, 32)), 32'd0);
        checkOutput("ar_fresh_s1",     32'(logSer[1]), 32'h1);
        checkOutput("ar_fresh_done",   32'(firstDone()), 32'd33);
        checkOutput("ar_fresh_ticks",  32'(countTicks(0, 35)), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
